// File: rtl/csr_unit_mu_if.sv
// Commit-side bus of the machine-mode CSR unit: retiring instruction, CSR
// access, trap inputs, interrupt lines and the redirect back to fetch.
interface csr_unit_mu_if #(
  parameter int XLEN = 64
);
  logic            stall;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_next_pc;
  logic            csr_we;
  logic [11:0]     csr_wa;
  logic [XLEN-1:0] csr_wd;
  logic [11:0]     csr_ra;
  logic [XLEN-1:0] csr_rd;
  logic            csr_ra_illegal;
  logic            is_mret;
  logic            is_ecall;
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic            trint;
  logic            swint;
  logic            exint;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      priv_mode;

  modport master (
    output stall, commit_valid, commit_pc, commit_next_pc, csr_we, csr_wa, csr_wd,
           csr_ra, is_mret, is_ecall, exc_valid, exc_code, exc_tval, trint, swint, exint,
    input  csr_rd, csr_ra_illegal, redirect_valid, redirect_pc, priv_mode
  );

  modport slave (
    input  stall, commit_valid, commit_pc, commit_next_pc, csr_we, csr_wa, csr_wd,
           csr_ra, is_mret, is_ecall, exc_valid, exc_code, exc_tval, trint, swint, exint,
    output csr_rd, csr_ra_illegal, redirect_valid, redirect_pc, priv_mode
  );
endinterface

// File: rtl/csr_unit_mu.sv
// Machine-mode CSR file and trap sequencer with M/U privilege tracking.
// Define CSR_VECTORED_MTVEC_EN to enable vectored interrupt entry via mtvec[1:0].
module csr_unit_mu #(
  parameter int          XLEN        = 64,
  parameter logic [63:0] RESET_MTVEC = 64'h8000_0000,
  parameter logic [63:0] RESET_PC    = 64'h8000_0000
) (
  input logic         clk,
  input logic         reset,
  csr_unit_mu_if.slave bus
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  logic            st_mie, st_mpie;
  logic [1:0]      st_mpp, priv_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q, pc_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] mstatus_val, mip_val, rd_val;
  logic            ra_impl;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mstatus_val       = '0;
    mstatus_val[3]    = st_mie;
    mstatus_val[7]    = st_mpie;
    mstatus_val[12:11] = st_mpp;
    mip_val           = '0;
    mip_val[3]        = bus.swint;
    mip_val[7]        = bus.trint;
    mip_val[11]       = bus.exint;
  end

  always_comb begin
    rd_val  = '0;
    ra_impl = 1'b1;
    case (bus.csr_ra)
      A_MSTATUS:  rd_val = mstatus_val;
      A_MIE:      rd_val = mie_q;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MTVAL:    rd_val = mtval_q;
      A_MIP:      rd_val = mip_val;
      A_MCYCLE:   rd_val = mcycle_q;
      A_MINSTRET: rd_val = minstret_q;
      default:    ra_impl = 1'b0;
    endcase
  end

  assign bus.csr_rd         = rd_val;
  assign bus.csr_ra_illegal = !ra_impl || (priv_q == PRIV_U);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.priv_mode      = priv_q;

  // Event arbitration: each lower-priority event is masked by all higher ones.
  logic            cv, take_exc, take_ecall, take_mret, take_csr, take_irq, take_trap;
  logic            irq_en, csr_write;
  logic [XLEN-1:0] irq_pend;
  logic [3:0]      irq_code;

  assign cv         = bus.commit_valid;
  assign take_exc   = cv && bus.exc_valid;
  assign take_ecall = cv && bus.is_ecall && !bus.exc_valid;
  assign take_mret  = cv && bus.is_mret && !bus.exc_valid && !bus.is_ecall;
  assign take_csr   = cv && bus.csr_we && !bus.exc_valid && !bus.is_ecall && !bus.is_mret;
  assign irq_en     = (priv_q == PRIV_U) || st_mie;
  assign irq_pend   = mip_val & mie_q;
  assign take_irq   = irq_en && (irq_pend[11] || irq_pend[3] || irq_pend[7]) &&
                      !take_exc && !take_ecall && !take_mret && !take_csr;
  assign take_trap  = take_exc || take_ecall || take_irq;
  assign csr_write  = take_csr && (priv_q == PRIV_M);
  assign irq_code   = irq_pend[11] ? 4'd11 : (irq_pend[3] ? 4'd3 : 4'd7);

  logic [XLEN-1:0] trap_cause, trap_tval, trap_epc, trap_target;

  always_comb begin
    trap_cause  = '0;
    trap_tval   = '0;
    trap_epc    = bus.commit_pc;
    trap_target = {mtvec_q[XLEN-1:2], 2'b00};
    if (take_exc) begin
      trap_cause[3:0] = bus.exc_code;
      trap_tval       = bus.exc_tval;
    end else if (take_ecall) begin
      trap_cause[3:0] = (priv_q == PRIV_U) ? 4'd8 : 4'd11;
    end else begin
      trap_cause[XLEN-1] = 1'b1;
      trap_cause[3:0]    = irq_code;
      if (!cv) trap_epc  = pc_q;
`ifdef CSR_VECTORED_MTVEC_EN
      if (mtvec_q[1:0] == 2'b01)
        trap_target = {mtvec_q[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments
  // in the same block (CSR writes) deliberately override earlier defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie           <= 1'b0;
      st_mpie          <= 1'b0;
      st_mpp           <= PRIV_U;
      priv_q           <= PRIV_M;
      mie_q            <= '0;
      mtvec_q          <= RESET_MTVEC[XLEN-1:0];
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mcycle_q         <= '0;
      minstret_q       <= '0;
      pc_q             <= RESET_PC[XLEN-1:0];
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mcycle_q         <= mcycle_q + XLEN'(1);
      redirect_valid_q <= 1'b0;
      if (!bus.stall) begin
        if (take_trap) begin
          mepc_q           <= {trap_epc[XLEN-1:2], 2'b00};
          mcause_q         <= trap_cause;
          mtval_q          <= trap_tval;
          st_mpie          <= st_mie;
          st_mie           <= 1'b0;
          st_mpp           <= priv_q;
          priv_q           <= PRIV_M;
          pc_q             <= trap_target;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= trap_target;
        end else if (take_mret) begin
          st_mie           <= st_mpie;
          st_mpie          <= 1'b1;
          priv_q           <= st_mpp;
          st_mpp           <= PRIV_U;
          minstret_q       <= minstret_q + XLEN'(1);
          pc_q             <= mepc_q;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= mepc_q;
        end else begin
          if (cv) begin
            pc_q       <= bus.commit_next_pc;
            minstret_q <= minstret_q + XLEN'(1);
          end
          if (csr_write) begin
            case (bus.csr_wa)
              A_MSTATUS: begin
                st_mie  <= bus.csr_wd[3];
                st_mpie <= bus.csr_wd[7];
                st_mpp  <= (bus.csr_wd[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
              end
              A_MIE:      mie_q      <= bus.csr_wd;
`ifdef CSR_VECTORED_MTVEC_EN
              A_MTVEC:    mtvec_q    <= {bus.csr_wd[XLEN-1:2],
                                         (bus.csr_wd[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
              A_MTVEC:    mtvec_q    <= {bus.csr_wd[XLEN-1:2], 2'b00};
`endif
              A_MSCRATCH: mscratch_q <= bus.csr_wd;
              A_MEPC:     mepc_q     <= {bus.csr_wd[XLEN-1:2], 2'b00};
              A_MCAUSE:   mcause_q   <= bus.csr_wd;
              A_MTVAL:    mtval_q    <= bus.csr_wd;
              A_MCYCLE:   mcycle_q   <= bus.csr_wd;
              A_MINSTRET: minstret_q <= bus.csr_wd;
              default: ;
            endcase
          end
        end
      end
    end
  end
endmodule

// File: doc/csr_unit_mu.md
Name: csr_unit_mu

Overview:
- Machine-mode CSR file with trap sequencer, M/U privilege tracking, prioritised interrupts, configurable vectored trap entry and retired-instruction counting.
- Sits at the commit (memory/writeback) boundary. Consumes one retiring instruction per cycle and produces a registered one-cycle redirect (trap entry or mret) to fetch.

Parameters:
- XLEN, 64, register and data width; legal values 32 or 64.
- RESET_MTVEC, 64'h8000_0000, reset value of mtvec; low 2 bits must be 0.
- RESET_PC, 64'h8000_0000, reset value of the internal next-pc tracker.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  freeze architectural updates and redirect
- commit_valid  in  1  instruction retiring this cycle
- commit_pc  in  XLEN  pc of retiring instruction
- commit_next_pc  in  XLEN  its successor pc (jump target or pc+4)
- csr_we  in  1  CSR write by retiring instruction
- csr_wa  in  12  write address
- csr_wd  in  XLEN  write data (already merged for csrrs/csrrc)
- csr_ra  in  12  read address
- csr_rd  out  XLEN  read data, combinational
- csr_ra_illegal  out  1  csr_ra unimplemented, or current mode is U
- is_mret  in  1  retiring mret
- is_ecall  in  1  retiring ecall
- exc_valid  in  1  retiring instruction raised a synchronous exception
- exc_code  in  4  mcause code for exc_valid
- exc_tval  in  XLEN  mtval value for exc_valid
- trint, swint, exint  in  1 each  level interrupt lines
- redirect_valid  out  1  registered pulse
- redirect_pc  out  XLEN  target pc when redirect_valid=1
- priv_mode  out  2  2'b11 = M, 2'b00 = U

Behaviour:
- Implemented CSRs: mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret.
  - mstatus: only MIE[3], MPIE[7], MPP[12:11] are writable; other bits read 0. A write of MPP=2'b01 or 2'b10 stores 2'b00.
  - mip: bits 7/3/11 mirror trint/swint/exint. Writes to mip are ignored.
  - mepc: bits[1:0] read 0.
  - Writes to unimplemented addresses are ignored.
- Reset values: all CSRs 0 except mtvec=RESET_MTVEC. priv_mode=M. pc tracker=RESET_PC. redirect_valid=0. redirect_pc=0.
- mcycle increments every cycle, including while stall=1. A CSR write to mcycle in the same cycle wins over the increment.
- When stall=1, no other state changes and redirect_valid is driven 0.
- Pc tracker:
  - On commit_valid without a trap, tracker <= commit_next_pc.
  - On a trap or mret, tracker <= redirect target.
- Event priority per non-stalled cycle (highest first):
  1. exc_valid
  2. is_ecall
  3. is_mret
  4. csr_we
  5. interrupt
  Lower-priority events in the same cycle are dropped. exc/ecall/mret/csr_we are qualified by commit_valid.
- Exception/ecall entry:
  - mepc=commit_pc.
  - mcause = exc_code, or for ecall 8 (from U) / 11 (from M). MSB of mcause = 0.
  - mtval = exc_tval for exceptions, 0 for ecall.
  - MPIE<=MIE, MIE<=0, MPP<=priv_mode, priv_mode<=M.
  - minstret is not incremented.
- Interrupts:
  - Enabled when (priv_mode==U or mstatus.MIE) and the mie bit is set.
  - Priority among sources: external (11) > software (3) > timer (7).
  - Entry: mepc = commit_pc if commit_valid, else tracker. The committing instruction is squashed and not counted.
  - mcause = {1'b1, code}. mtval=0. mstatus/mode updates as for exceptions.
- mret:
  - MIE<=MPIE, MPIE<=1, priv_mode<=MPP, MPP<=U.
  - redirect_pc=mepc. minstret increments.
- Trap target is mtvec with bits[1:0] cleared (see optional feature).
- minstret increments on commit_valid with no trap. A CSR write to minstret takes precedence over the increment.
- redirect_valid asserts exactly one cycle after the triggering non-stalled cycle, for one cycle.
- In U mode a csr_we is not performed. The decoder must raise exc_valid (code 2) using csr_ra_illegal.

Optional Feature:
- Macro: CSR_VECTORED_MTVEC_EN.
- With the macro:
  - mtvec[1:0]==2'b01 selects vectored mode. Interrupt target = {mtvec[XLEN-1:2],2'b00} + 4*cause_code. Exceptions still use the base address.
  - mtvec[1:0] is writable with values 0/1; writes of 2 or 3 store 0.
- Without the macro: mtvec[1:0] always reads 0 and every trap uses the base address.

Test Plan:
- Reset, then read mtvec/mstatus/mcycle -> 0x80000000 / 0 / increments each cycle; priv_mode=3.
- mtvec=0x1000. In M mode, ecall at pc 0x200 -> next cycle redirect_valid=1 with pc 0x1000; mepc=0x200, mcause=11, MIE=0, MPP=3.
- Set MPP=0, then mret with mepc=0x300 -> redirect to 0x300, priv_mode=0. A following ecall gives mcause=8, MPP=0.
- MIE=1, mie=0x888, trint=swint=exint=1 with commit pc 0x400 -> mcause=0x8000…000B, mepc=0x400, minstret not incremented.
- exc_valid (code 4) and is_ecall together, stall held 3 cycles -> no change until stall drops, then mcause=4 and mtval=exc_tval.
- With CSR_VECTORED_MTVEC_EN, mtvec=0x1001, timer interrupt -> redirect_pc=0x101C.
